pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL take parameter DATA_W, default 19: instruction payload width.
REQ-002 The block SHALL take parameter PC_W, default 12: PC payload width.
REQ-003 The block SHALL take parameter CNT_W, default 16: stall-counter width.
REQ-004 Clock and reset SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port reset  input  1  synchronous active-high reset.
REQ-007 Port flush  input  1  discard all held entries; drive NOP bubble.
REQ-008 Port in_valid  input  1  upstream (IF) offers an entry.
REQ-009 Port in_ready  output  1  stage can accept an entry this cycle.
REQ-010 Port in_inst  input  DATA_W  fetched instruction.
REQ-011 Port in_pc  input  PC_W  PC+1 of the fetched instruction.
REQ-012 Port out_valid  output  1  entry presented to ID.
REQ-013 Port out_ready  input  1  ID consumes the entry (low = stall).
REQ-014 Port out_inst  output  DATA_W  instruction to ID.
REQ-015 Port out_pc  output  PC_W  PC to ID.
REQ-016 Port stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-017 Handshake: transfer on a port occurs when valid and ready are both high at a rising edge.
REQ-018 Storage SHALL be a main register (drives outputs) plus one skid register.
REQ-019 FSM states SHALL be EMPTY (0 held), FULL (main held), SKID (main+skid held).
REQ-020 in_ready SHALL be registered: high in EMPTY and FULL, low in SKID; no combinational path from out_ready.
REQ-021 EMPTY: in accept -> FULL, main loaded.
REQ-022 FULL: in accept and out consume -> FULL, main reloaded; in accept only -> SKID, entry into skid; out consume only -> EMPTY.
REQ-023 SKID: out consume -> FULL, skid moved to main; no in accept possible.
REQ-024 Entry order SHALL be preserved; no entry dropped or duplicated without flush.
REQ-025 out_valid SHALL be high in FULL and SKID only.
REQ-026 When out_valid low, out_inst and out_pc SHALL be all zeros (NOP bubble).
REQ-027 flush SHALL, at the edge, empty both registers, go to EMPTY, and zero payloads; outputs zero the following cycle.
REQ-028 flush SHALL override a simultaneous in-accept or out-consume; the incoming entry is discarded.
REQ-029 stall_cnt SHALL increment by 1 each cycle out_valid=1 and out_ready=0, saturating at 2^CNT_W-1, not cleared by flush.
REQ-030 Latency: an entry accepted in EMPTY SHALL appear on outputs the next cycle.
REQ-031 Throughput: with out_ready held high, one entry per cycle SHALL pass with no bubbles.

Reset
REQ-032 Reset SHALL force EMPTY, in_ready=1, out_valid=0, out_inst=0, out_pc=0, stall_cnt=0 by the next edge.
REQ-033 Reset mid-operation SHALL discard held entries and take priority over flush and handshakes.

Structure
REQ-034 FSM state enum and NOP encoding (all zeros) SHALL live in shared package pipe_pkg.
REQ-035 Width defaults (DATA_W, PC_W) SHALL come from pipe_pkg constants.
REQ-036 The stall counter SHALL be a sub-module sat_counter (CNT_W parameter, inc, clr inputs).

Verification
REQ-037 Reset, then in_valid=1, inst=0x1ABCD, pc=0x005, out_ready=1 -> next cycle out_valid=1, out_inst=0x1ABCD, out_pc=0x005.
REQ-038 Stream 8 entries with out_ready=1 -> 8 consecutive outputs in order, in_ready never low.
REQ-039 Hold out_ready=0 while sending A,B -> state SKID, in_ready=0, out shows A; release -> A then B, stall_cnt equals stalled cycles.
REQ-040 In SKID assert flush with in_valid=1 -> next cycle out_valid=0, outputs zero, in_ready=1, stall_cnt unchanged.
REQ-041 CNT_W=2, stall 6 cycles -> stall_cnt saturates at 3.
REQ-042 Assert reset during SKID with flush=1 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the IF->ID pipeline stage: state encoding,
// payload width defaults and the NOP bubble encoding.
package pipe_pkg;

    localparam int PIPE_DATA_W = 19;
    localparam int PIPE_PC_W   = 12;

    // A NOP bubble is an all-zeros payload; replicate this bit to any width.
    localparam logic NOP_BIT = 1'b0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // nothing held
        ST_FULL  = 2'd1,   // main register holds an entry
        ST_SKID  = 2'd2    // main and skid registers both hold entries
    } skid_state_t;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; used to count stall cycles.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;

    assign w_at_max = &r_cnt;
    assign cnt      = r_cnt;

    // Clear wins; otherwise count up and stick at all-ones.
    always_ff @(posedge clk) begin
        if (clr)
            r_cnt <= '0;
        else if (inc && !w_at_max)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// IF->ID pipeline register with a one-entry skid buffer. in_ready is a
// registered state decode, so out_ready never reaches in_ready
// combinationally; the skid register absorbs the one entry that can arrive
// in the cycle ID first stalls.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int PC_W   = PIPE_PC_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [DATA_W-1:0] NOP_INST = {DATA_W{NOP_BIT}};
    localparam logic [PC_W-1:0]   NOP_PC   = {PC_W{NOP_BIT}};

    skid_state_t       r_state;
    skid_state_t       w_next;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_inst;
    logic [DATA_W-1:0] r_skid_inst;
    logic [PC_W-1:0]   r_main_pc;
    logic [PC_W-1:0]   r_skid_pc;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_stall;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid && r_in_ready;
    assign w_out_fire  = w_out_valid && out_ready;
    assign w_stall     = w_out_valid && !out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_inst  = w_out_valid ? r_main_inst : NOP_INST;
    assign out_pc    = w_out_valid ? r_main_pc   : NOP_PC;

    // Next-state decode from the two handshakes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_EMPTY: if (w_in_fire) w_next = ST_FULL;
            ST_FULL: begin
                if (w_in_fire && !w_out_fire)      w_next = ST_SKID;
                else if (!w_in_fire && w_out_fire) w_next = ST_EMPTY;
            end
            ST_SKID:  if (w_out_fire) w_next = ST_FULL;
            default:  w_next = ST_EMPTY;
        endcase
    end

    // State register and registered in_ready; reset and flush both empty the stage.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != ST_SKID);
        end
    end

    // Payload movement: load main, spill to skid, or promote skid to main.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_main_inst <= NOP_INST;
            r_main_pc   <= NOP_PC;
            r_skid_inst <= NOP_INST;
            r_skid_pc   <= NOP_PC;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main_inst <= in_inst;
                        r_main_pc   <= in_pc;
                    end
                end
                ST_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_inst <= in_inst;
                        r_main_pc   <= in_pc;
                    end else if (w_in_fire) begin
                        r_skid_inst <= in_inst;
                        r_skid_pc   <= in_pc;
                    end else if (w_out_fire) begin
                        r_main_inst <= NOP_INST;
                        r_main_pc   <= NOP_PC;
                    end
                end
                ST_SKID: begin
                    if (w_out_fire) begin
                        r_main_inst <= r_skid_inst;
                        r_main_pc   <= r_skid_pc;
                        r_skid_inst <= NOP_INST;
                        r_skid_pc   <= NOP_PC;
                    end
                end
                default: begin
                    r_main_inst <= NOP_INST;
                    r_main_pc   <= NOP_PC;
                end
            endcase
        end
    end

    // Stall counter survives flush; only reset clears it.
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .inc (w_stall),
        .clr (reset),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid. A second instance with CNT_W=2 shares
// all inputs so stall-counter saturation is observed on the same traffic.
module tb_pipe_stage_skid;

    localparam int DATA_W = 19;
    localparam int PC_W   = 12;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, out_ready;
    logic [DATA_W-1:0] in_inst;
    logic [PC_W-1:0]   in_pc;

    logic              a_in_ready, a_out_valid;
    logic [DATA_W-1:0] a_out_inst;
    logic [PC_W-1:0]   a_out_pc;
    logic [15:0]       a_stall;

    logic              b_in_ready, b_out_valid;
    logic [DATA_W-1:0] b_out_inst;
    logic [PC_W-1:0]   b_out_pc;
    logic [1:0]        b_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_inst(a_out_inst),
        .out_pc(a_out_pc), .stall_cnt(a_stall)
    );

    pipe_stage_skid #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_inst(b_out_inst),
        .out_pc(b_out_pc), .stall_cnt(b_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [31:0] exp_a_stall,
                            input logic [31:0] exp_b_stall);
        chk({tag, ".in_ready"},  32'(a_in_ready),  32'd1);
        chk({tag, ".out_valid"}, 32'(a_out_valid), 32'd0);
        chk({tag, ".out_inst"},  32'(a_out_inst),  32'd0);
        chk({tag, ".out_pc"},    32'(a_out_pc),    32'd0);
        chk({tag, ".stall_a"},   32'(a_stall),     exp_a_stall);
        chk({tag, ".stall_b"},   32'(b_stall),     exp_b_stall);
        chk({tag, ".b_valid"},   32'(b_out_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        #2;
        tick();
        chk_idle("reset", 32'd0, 32'd0);

        // Single entry: visible one cycle after acceptance.
        reset = 1'b0; in_valid = 1'b1; in_inst = 19'h1ABCD; in_pc = 12'h005; out_ready = 1'b1;
        tick();
        chk("lat.valid", 32'(a_out_valid), 32'd1);
        chk("lat.inst",  32'(a_out_inst),  32'h1ABCD);
        chk("lat.pc",    32'(a_out_pc),    32'h005);

        // Streaming: one entry per cycle, in order, in_ready stays high.
        for (int i = 0; i < 8; i++) begin
            in_inst = 19'(32'h100 + i); in_pc = 12'(i + 1);
            tick();
            chk($sformatf("strm%0d.valid", i), 32'(a_out_valid), 32'd1);
            chk($sformatf("strm%0d.inst", i),  32'(a_out_inst),  32'h100 + 32'(i));
            chk($sformatf("strm%0d.pc", i),    32'(a_out_pc),    32'(i + 1));
            chk($sformatf("strm%0d.rdy", i),   32'(a_in_ready),  32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk_idle("drain", 32'd0, 32'd0);

        // Stall with A then B: reach SKID, then release in order.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 19'h0AAAA; in_pc = 12'h00A;
        tick();
        chk("stlA.inst",  32'(a_out_inst), 32'h0AAAA);
        chk("stlA.stall", 32'(a_stall),    32'd0);
        in_inst = 19'h0BBBB; in_pc = 12'h00B;
        tick();
        chk("skid.rdy",   32'(a_in_ready), 32'd0);
        chk("skid.inst",  32'(a_out_inst), 32'h0AAAA);
        chk("skid.pc",    32'(a_out_pc),   32'h00A);
        chk("skid.stall", 32'(a_stall),    32'd1);
        in_valid = 1'b0;
        tick();
        chk("skid2.inst",  32'(a_out_inst), 32'h0AAAA);
        chk("skid2.stall", 32'(a_stall),    32'd2);
        chk("skid2.b",     32'(b_stall),    32'd2);
        out_ready = 1'b1;
        tick();
        chk("relB.valid", 32'(a_out_valid), 32'd1);
        chk("relB.inst",  32'(a_out_inst),  32'h0BBBB);
        chk("relB.pc",    32'(a_out_pc),    32'h00B);
        chk("relB.rdy",   32'(a_in_ready),  32'd1);
        chk("relB.stall", 32'(a_stall),     32'd2);
        tick();
        chk_idle("relEnd", 32'd2, 32'd2);

        // Fill to SKID again, then flush with a competing input entry.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 19'h0CCCC; in_pc = 12'h00C;
        tick();
        in_inst = 19'h0DDDD; in_pc = 12'h00D;
        tick();
        chk("skid3.rdy",   32'(a_in_ready), 32'd0);
        chk("skid3.stall", 32'(a_stall),    32'd3);
        flush = 1'b1; out_ready = 1'b1; in_inst = 19'h0EEEE; in_pc = 12'h00E;
        tick();
        chk_idle("flush", 32'd3, 32'd3);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk_idle("postflush", 32'd3, 32'd3);

        // Six stalled cycles: 16-bit counter reaches 9, 2-bit one holds at 3.
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 19'h0F0F0; in_pc = 12'h0F0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("sat.a",    32'(a_stall),    32'd9);
        chk("sat.b",    32'(b_stall),    32'd3);
        chk("sat.inst", 32'(a_out_inst), 32'h0F0F0);

        // Reach SKID, then reset together with flush and handshakes.
        in_valid = 1'b1; in_inst = 19'h01111; in_pc = 12'h111;
        tick();
        chk("skid4.rdy",   32'(a_in_ready), 32'd0);
        chk("skid4.stall", 32'(a_stall),    32'd10);
        reset = 1'b1; flush = 1'b1; out_ready = 1'b1;
        tick();
        chk_idle("rstSkid", 32'd0, 32'd0);
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        chk_idle("postRst", 32'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
